roll_controller: RTL and testbench

ROLL_CONTROLLER -- requirements
Module: roll_controller

---
 rtl/roll_controller_pkg.sv | 29 ++
 rtl/roll_controller_mod_unit.sv | 64 ++++++
 rtl/roll_controller.sv | 168 ++++++++++++++++
 tb/tb_roll_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/roll_controller_pkg.sv
// Shared definitions for the dice roll controller: default widths, FSM state
// encoding and the power-of-two mask helper used by the rejection reducer.
package roll_controller_pkg;

  localparam int SIDES_W = 8;
  localparam int DICE_W  = 4;
  localparam int TOTAL_W = 12;
  localparam int RNG_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    REDUCE,
    ACC,
    FIN
  } state_e;

  // (smallest power of two >= sides) - 1: smear the top set bit of sides-1 downward.
  function automatic logic [RNG_W-1:0] reject_mask(input logic [RNG_W-1:0] sides);
    logic [RNG_W-1:0] m;
    m = sides - RNG_W'(1);
    for (int i = 1; i < RNG_W; i = i * 2) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

endpackage

// File: rtl/roll_controller_mod_unit.sv
// Restoring remainder unit: one dividend bit per cycle, 32 iterations after
// start, then a one-cycle done pulse with remainder = dividend mod divisor.
module mod_unit #(
  parameter int SIDES_W = roll_controller_pkg::SIDES_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        dividend,
  input  logic [SIDES_W-1:0] divisor,
  output logic               done,
  output logic [SIDES_W-1:0] remainder
);
  import roll_controller_pkg::*;

  logic [31:0]        r_dvd;
  logic [SIDES_W-1:0] r_div;
  logic [SIDES_W-1:0] r_rem;
  logic [4:0]         r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [SIDES_W:0]   w_shift;
  logic               w_ge;
  logic [SIDES_W-1:0] w_sub;

  // Partial remainder stays below the divisor, so the shifted value needs one extra bit.
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[SIDES_W-1:0] - r_div;

  // NOTE: non-blocking assignments so every register sees pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_busy) begin
        r_dvd  <= dividend;
        r_div  <= divisor;
        r_rem  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_dvd <= r_dvd << 1;
        r_rem <= w_ge ? w_sub : w_shift[SIDES_W-1:0];
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done      = r_done;
  assign remainder = r_rem;

endmodule

// File: rtl/roll_controller.sv
// Dice roll controller: requests RNG words, reduces each to 0..sides-1 and sums
// value+1 per die. Define ROLL_REJECT_EN for mask-and-reject reduction; default uses mod_unit.
module roll_controller #(
  parameter int SIDES_W = roll_controller_pkg::SIDES_W,
  parameter int DICE_W  = roll_controller_pkg::DICE_W,
  parameter int TOTAL_W = roll_controller_pkg::TOTAL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               roll_start,
  input  logic [SIDES_W-1:0] sides,
  input  logic [DICE_W-1:0]  num_dice,
  output logic               busy,
  output logic [TOTAL_W-1:0] total,
  output logic               done,
  output logic               err,
  output logic               rng_start,
  input  logic [31:0]        rng_result,
  input  logic               rng_done
);
  import roll_controller_pkg::*;

  state_e             r_state;
  logic [SIDES_W-1:0] r_sides;
  logic [DICE_W-1:0]  r_num;
  logic [DICE_W-1:0]  r_cnt;
  logic [TOTAL_W-1:0] r_total;
  logic [31:0]        r_word;
  logic [SIDES_W-1:0] r_v;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_rng_start;

  logic [DICE_W-1:0]  w_cnt_next;

  assign w_cnt_next = r_cnt + DICE_W'(1);

`ifdef ROLL_REJECT_EN
  logic [31:0] w_masked;
  logic        w_reject;

  assign w_masked = r_word & reject_mask(32'(r_sides));
  assign w_reject = (w_masked >= 32'(r_sides));
`else
  logic               r_mod_start;
  logic               w_mod_done;
  logic [SIDES_W-1:0] w_mod_rem;

  mod_unit #(
    .SIDES_W (SIDES_W)
  ) u_mod_unit (
    .clk       (clk),
    .reset     (reset),
    .start     (r_mod_start),
    .dividend  (r_word),
    .divisor   (r_sides),
    .done      (w_mod_done),
    .remainder (w_mod_rem)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sides     <= '0;
      r_num       <= '0;
      r_cnt       <= '0;
      r_total     <= '0;
      r_word      <= '0;
      r_v         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rng_start <= 1'b0;
`ifndef ROLL_REJECT_EN
      r_mod_start <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (roll_start) begin
            r_sides <= sides;
            r_num   <= num_dice;
            r_total <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (sides < SIDES_W'(2)) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= FIN;
            end else if (num_dice == '0) begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_rng_start <= 1'b1;
              r_state     <= REQ;
            end
          end
        end

        REQ: begin
          r_rng_start <= 1'b0;
          r_state     <= WAIT;
        end

        WAIT: begin
          if (rng_done) begin
            r_word  <= rng_result;
            r_state <= REDUCE;
`ifndef ROLL_REJECT_EN
            r_mod_start <= 1'b1;
`endif
          end
        end

`ifdef ROLL_REJECT_EN
        REDUCE: begin
          if (w_reject) begin
            r_rng_start <= 1'b1;
            r_state     <= REQ;
          end else begin
            r_v     <= w_masked[SIDES_W-1:0];
            r_state <= ACC;
          end
        end
`else
        REDUCE: begin
          r_mod_start <= 1'b0;
          if (w_mod_done) begin
            r_v     <= w_mod_rem;
            r_state <= ACC;
          end
        end
`endif

        ACC: begin
          // Worst case 15 dice * 255 = 3825 fits TOTAL_W, so no saturation logic.
          r_total <= r_total + TOTAL_W'(r_v) + TOTAL_W'(1);
          r_cnt   <= w_cnt_next;
          if (w_cnt_next == r_num) begin
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_rng_start <= 1'b1;
            r_state     <= REQ;
          end
        end

        FIN: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign total     = r_total;
  assign done      = r_done;
  assign err       = r_err;
  assign rng_start = r_rng_start;

endmodule

// File: tb/tb_roll_controller.sv
// Scoreboard bench for roll_controller: an RNG responder feeds queued words,
// expected results are queued per roll and popped on done.
module tb_roll_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        roll_start;
  logic [7:0]  sides;
  logic [3:0]  num_dice;
  logic        busy;
  logic [11:0] total;
  logic        done;
  logic        err;
  logic        rng_start;
  logic [31:0] rng_result;
  logic        rng_done;

  always #5 clk = ~clk;

  roll_controller #(
    .SIDES_W (8),
    .DICE_W  (4),
    .TOTAL_W (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .roll_start (roll_start),
    .sides      (sides),
    .num_dice   (num_dice),
    .busy       (busy),
    .total      (total),
    .done       (done),
    .err        (err),
    .rng_start  (rng_start),
    .rng_result (rng_result),
    .rng_done   (rng_done)
  );

  typedef struct {
    int total;
    int err;
    int starts;
  } exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rng_q[$];
  exp_t        exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  // Reference roll: consumes rng_q words in order without popping them.
  function automatic void model_roll(input int s, input int n, output int tot, output int st);
    int          idx;
    int          acc;
    logic [31:0] w;
    logic [31:0] v;
`ifdef ROLL_REJECT_EN
    logic [31:0] mask;
`endif
    idx = 0;
    acc = 0;
    tot = 0;
    st  = 0;
    if (s < 2 || n == 0) return;
`ifdef ROLL_REJECT_EN
    mask = 1;
    while (mask < s) mask = mask << 1;
    mask = mask - 1;
`endif
    while (acc < n) begin
      w = (idx < rng_q.size()) ? rng_q[idx] : 32'd0;
      idx++;
      st++;
`ifdef ROLL_REJECT_EN
      v = w & mask;
      if (v >= s) continue;
`else
      v = w % s;
`endif
      tot += int'(v) + 1;
      acc++;
    end
  endfunction

  // Starts a roll at the current negedge; returns at the negedge after done.
  task automatic roll(input string tag, input int s, input int n, input int exp_total,
                      input int exp_err, input int exp_starts, input bit poke);
    exp_t        e;
    int          starts;
    int          pending;
    int          delay;
    int          cyc;
    int          rd_cyc;
    int          done_cyc;
    bit          got;
    logic [31:0] word;
    starts = 0; pending = 0; delay = 0; cyc = 0; rd_cyc = 0; done_cyc = 0;
    got = 1'b0; word = '0;
    e.total = exp_total; e.err = exp_err; e.starts = exp_starts;
    exp_q.push_back(e);

    sides      = 8'(s);
    num_dice   = 4'(n);
    roll_start = 1'b1;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      roll_start = 1'b0;
      rng_done   = 1'b0;
      if (cyc == 1) check({tag, "_busy"}, busy, 1);
      if (poke && cyc == 3) begin
        roll_start = 1'b1;
        sides      = 8'd1;
        num_dice   = 4'd0;
      end
      if (rng_start) begin
        starts++;
        pending = 1;
        delay   = 2;
        word    = (rng_q.size() > 0) ? rng_q.pop_front() : 32'd0;
      end else if (pending != 0) begin
        if (delay == 0) begin
          rng_done   = 1'b1;
          rng_result = word;
          pending    = 0;
          rd_cyc     = cyc;
        end else begin
          delay--;
        end
      end
      if (done) begin
        got      = 1'b1;
        done_cyc = cyc;
        e        = exp_q.pop_front();
        check({tag, "_total"},  total,     e.total);
        check({tag, "_err"},    err,       e.err);
        check({tag, "_starts"}, starts,    e.starts);
        check({tag, "_busy_done"}, busy,   1);
      end
    end
    if (!got) check({tag, "_done_timeout"}, 0, 1);
`ifndef ROLL_REJECT_EN
    if (got && starts > 0) check({tag, "_mod_latency"}, 32'((done_cyc - rd_cyc) >= 32), 1);
`endif
    @(negedge clk);
    roll_start = 1'b0;
    rng_done   = 1'b0;
    check({tag, "_done_pulse"}, done,  0);
    check({tag, "_err_pulse"},  err,   0);
    check({tag, "_busy_end"},   busy,  0);
    check({tag, "_held"},       total, 32'(exp_total));
    rng_q.delete();
  endtask

  initial begin
    int t;
    int st;
    bit seen;
    reset      = 1'b1;
    roll_start = 1'b0;
    sides      = '0;
    num_dice   = '0;
    rng_result = '0;
    rng_done   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy,      0);
    check("rst_total", total,     0);
    check("rst_done",  done,      0);
    check("rst_err",   err,       0);
    check("rst_rngst", rng_start, 0);
    reset = 1'b0;

    rng_q = '{32'd3};
    roll("d6", 6, 1, 4, 0, 1, 1'b0);
`ifdef ROLL_REJECT_EN
    rng_q = '{32'd7, 32'd5};
    roll("rej", 6, 1, 6, 0, 2, 1'b0);
`else
    rng_q = '{32'hFFFF_FFFF};
    roll("mod", 6, 1, 4, 0, 1, 1'b0);
`endif
    rng_q = '{32'd0, 32'd19, 32'd10};
    roll("d20", 20, 3, 32, 0, 3, 1'b1);
    roll("s1", 1, 2, 0, 1, 0, 1'b0);
    roll("n0", 6, 0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 15; i++) rng_q.push_back(32'd254);
    roll("max", 255, 15, 3825, 0, 15, 1'b0);

    for (int i = 0; i < 30; i++) rng_q.push_back($urandom);
    model_roll(100, 7, t, st);
    roll("rand", 100, 7, t, 0, st, 1'b0);

    // Reset while waiting on the RNG, then a stray rng_done.
    sides      = 8'd6;
    num_dice   = 4'd2;
    roll_start = 1'b1;
    @(negedge clk);
    roll_start = 1'b0;
    check("mid_rngst", rng_start, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy",  busy,      0);
    check("mid_total", total,     0);
    check("mid_done",  done,      0);
    check("mid_err",   err,       0);
    check("mid_rngst0", rng_start, 0);
    rng_done   = 1'b1;
    rng_result = 32'd3;
    @(negedge clk);
    rng_done = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy || done || rng_start || err) seen = 1'b1;
    end
    check("mid_quiet", 32'(seen), 0);
    check("mid_total_held", total, 0);

    rng_q = '{32'd5};
    roll("post", 2, 1, 2, 0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
